// File: rtl/example_hmc_prbs_checker.sv
// Receive-side PRBS checker: self-seeds its LFSR from incoming words, locks after
// a run of matching words, then reports per-word bit errors and saturating statistics.
module example_hmc_prbs_checker #(
  parameter int unsigned DATA_WIDTH   = 48,
  parameter int unsigned PRBS_SIZE    = 15,
  parameter logic [PRBS_SIZE-1:0] PRBS_POLY = 15'b100000000000011,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 4,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear_cnt,
  input  logic                                 data_valid,
  input  logic [DATA_WIDTH-1:0]                data_in,
  output logic                                 locked,
  output logic                                 err_valid,
  output logic                                 err_word,
  output logic [$clog2(DATA_WIDTH+1)-1:0]      err_bits,
  output logic [CNT_WIDTH-1:0]                 word_cnt,
  output logic [CNT_WIDTH-1:0]                 err_bit_cnt,
  output logic [15:0]                          lock_loss_cnt
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned P     = PRBS_SIZE;
  localparam int unsigned EB_W  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned SUM_W = ((CNT_WIDTH > EB_W) ? CNT_WIDTH : EB_W) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [15:0]          LL_MAX  = '1;

  typedef enum logic [1:0] {SEEK, TRAIN, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [P-1:0]       exp_state, exp_nxt;
  logic [7:0]         good_cnt, good_nxt;
  logic [7:0]         bad_cnt, bad_nxt;
  logic               err_valid_nxt, err_word_nxt;
  logic [EB_W-1:0]    err_bits_nxt;
  logic [CNT_WIDTH-1:0] word_nxt, ebc_nxt;
  logic [15:0]        ll_nxt;

  function automatic logic [P-1:0] lfsr_step(input logic [P-1:0] s);
    return {^(PRBS_POLY & {1'b0, s[P-2:0]}), s[P-1:1]};
  endfunction

  function automatic logic [P-1:0] adv(input logic [P-1:0] s);
    logic [P-1:0] t;
    t = s;
    for (int i = 0; i < DW; i++) t = lfsr_step(t);
    return t;
  endfunction

  function automatic logic [DW-1:0] gen(input logic [P-1:0] s);
    logic [P-1:0]  t;
    logic [DW-1:0] w;
    t = s;
    w = '0;
    for (int i = 0; i < DW; i++) begin
      w[i] = t[0];
      t    = lfsr_step(t);
    end
    return w;
  endfunction

  logic [P-1:0]    seed;
  logic [DW-1:0]   diff;
  logic [EB_W-1:0] pop;
  logic [SUM_W-1:0] ebc_sum;
  logic [7:0]      good_inc, bad_inc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEEK;
    else     state <= state_nxt;
  end

  // Next state, LFSR tracking, error reporting and statistics
  always_comb begin
    state_nxt     = state;
    exp_nxt       = exp_state;
    good_nxt      = good_cnt;
    bad_nxt       = bad_cnt;
    err_valid_nxt = 1'b0;
    err_word_nxt  = 1'b0;
    err_bits_nxt  = '0;
    word_nxt      = word_cnt;
    ebc_nxt       = err_bit_cnt;
    ll_nxt        = lock_loss_cnt;
    seed          = data_in[P-1:0];
    diff          = data_in ^ gen(exp_state);
    good_inc      = good_cnt + 8'd1;
    bad_inc       = bad_cnt + 8'd1;
    pop           = '0;
    for (int i = 0; i < DW; i++) pop = pop + EB_W'(diff[i]);
    ebc_sum       = SUM_W'(err_bit_cnt) + SUM_W'(pop);

    if (data_valid) begin
      case (state)
        SEEK: begin
          if (seed != '0) begin
            exp_nxt   = adv(seed);
            good_nxt  = 8'd0;
            state_nxt = TRAIN;
          end
        end
        TRAIN: begin
          if (diff == '0) begin
            exp_nxt  = adv(exp_state);
            good_nxt = good_inc;
            if (good_inc == 8'(LOCK_COUNT)) begin
              state_nxt = LOCKED;
              bad_nxt   = 8'd0;
            end
          end else begin
            good_nxt = 8'd0;
            if (seed == '0) begin
              state_nxt = SEEK;
            end else begin
              exp_nxt = adv(seed);
            end
          end
        end
        LOCKED: begin
          exp_nxt       = adv(exp_state);
          err_valid_nxt = 1'b1;
          err_word_nxt  = (diff != '0);
          err_bits_nxt  = pop;
          if (word_cnt != CNT_MAX) word_nxt = word_cnt + CNT_WIDTH'(1);
          ebc_nxt = (ebc_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_WIDTH'(ebc_sum);
          if (diff != '0) begin
            bad_nxt = bad_inc;
            if (bad_inc == 8'(UNLOCK_COUNT)) begin
              state_nxt = SEEK;
              if (lock_loss_cnt != LL_MAX) ll_nxt = lock_loss_cnt + 16'd1;
            end
          end else begin
            bad_nxt = 8'd0;
          end
        end
        default: state_nxt = SEEK;
      endcase
    end

    // Clearing wins over any increment in the same cycle
    if (clear_cnt) begin
      word_nxt = '0;
      ebc_nxt  = '0;
      ll_nxt   = '0;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_state     <= '0;
      good_cnt      <= '0;
      bad_cnt       <= '0;
      locked        <= 1'b0;
      err_valid     <= 1'b0;
      err_word      <= 1'b0;
      err_bits      <= '0;
      word_cnt      <= '0;
      err_bit_cnt   <= '0;
      lock_loss_cnt <= '0;
    end else begin
      exp_state     <= exp_nxt;
      good_cnt      <= good_nxt;
      bad_cnt       <= bad_nxt;
      locked        <= (state_nxt == LOCKED);
      err_valid     <= err_valid_nxt;
      err_word      <= err_word_nxt;
      err_bits      <= err_bits_nxt;
      word_cnt      <= word_nxt;
      err_bit_cnt   <= ebc_nxt;
      lock_loss_cnt <= ll_nxt;
    end
  end

endmodule

// File: tb/tb_example_hmc_prbs_checker.sv
// Directed bench for example_hmc_prbs_checker: lock, bit errors, lock loss, gaps,
// counter clear/saturation and asynchronous reset.
module tb_example_hmc_prbs_checker;

  localparam int unsigned DW = 48;
  localparam int unsigned EB = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_cnt = 1'b0;
  logic          data_valid = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic          locked, err_valid, err_word;
  logic [EB-1:0] err_bits;
  logic [31:0]   word_cnt, err_bit_cnt;
  logic [15:0]   lock_loss_cnt;

  logic          s_locked, s_err_valid, s_err_word;
  logic [EB-1:0] s_err_bits;
  logic [3:0]    s_word_cnt, s_err_bit_cnt;
  logic [15:0]   s_lock_loss_cnt;

  example_hmc_prbs_checker dut (
    .clk(clk), .rst(rst), .clear_cnt(clear_cnt), .data_valid(data_valid),
    .data_in(data_in), .locked(locked), .err_valid(err_valid), .err_word(err_word),
    .err_bits(err_bits), .word_cnt(word_cnt), .err_bit_cnt(err_bit_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  example_hmc_prbs_checker #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .clear_cnt(clear_cnt), .data_valid(data_valid),
    .data_in(data_in), .locked(s_locked), .err_valid(s_err_valid), .err_word(s_err_word),
    .err_bits(s_err_bits), .word_cnt(s_word_cnt), .err_bit_cnt(s_err_bit_cnt),
    .lock_loss_cnt(s_lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [14:0] g;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference generator: x^15 + x^14 + 1, bit 0 earliest
  task automatic next_word(output logic [DW-1:0] w);
    w = '0;
    for (int i = 0; i < DW; i++) begin
      w[i] = g[0];
      g = {g[0] ^ g[1], g[14:1]};
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic v, input logic clr);
    @(negedge clk);
    data_in    = d;
    data_valid = v;
    clear_cnt  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_clean();
    logic [DW-1:0] w;
    next_word(w);
    send(w, 1'b1, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] ones;
    ones = '1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    chk("rst_lock_loss", 64'(lock_loss_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Lock from seed 1: first word's low 15 bits are the seed itself
    g = 15'h0001;
    for (int i = 1; i <= 5; i++) begin
      if (i == 1) chk("seed_word_low", 64'(g), 64'h0001);
      send_clean();
      chk($sformatf("lock_w%0d", i), 64'(locked), 64'(i == 5));
      chk($sformatf("lock_ev_w%0d", i), 64'(err_valid), 64'd0);
    end
    chk("lock_word_cnt", 64'(word_cnt), 64'd0);

    for (int i = 0; i < 10; i++) begin
      send_clean();
      chk("clean_err_word", 64'({err_valid, err_word}), 64'b10);
    end
    chk("clean_word_cnt", 64'(word_cnt), 64'd10);
    chk("clean_err_bit_cnt", 64'(err_bit_cnt), 64'd0);

    // Single bit error at bit 7
    next_word(w);
    w[7] = ~w[7];
    send(w, 1'b1, 1'b0);
    chk("sbe_valid", 64'(err_valid), 64'd1);
    chk("sbe_word", 64'(err_word), 64'd1);
    chk("sbe_bits", 64'(err_bits), 64'd1);
    chk("sbe_locked", 64'(locked), 64'd1);
    chk("sbe_err_bit_cnt", 64'(err_bit_cnt), 64'd1);
    send_clean();
    chk("sbe_next_word", 64'(err_word), 64'd0);
    chk("sbe_next_bits", 64'(err_bits), 64'd0);
    chk("sbe_word_cnt", 64'(word_cnt), 64'd12);

    // Lock loss via four all-ones words
    for (int i = 1; i <= 4; i++) begin
      next_word(w);
      send(ones, 1'b1, 1'b0);
      chk($sformatf("ll_err_w%0d", i), 64'({err_valid, err_word}), 64'b11);
      chk($sformatf("ll_locked_w%0d", i), 64'(locked), 64'(i != 4));
    end
    chk("ll_cnt", 64'(lock_loss_cnt), 64'd1);
    chk("ll_word_cnt", 64'(word_cnt), 64'd16);

    for (int i = 1; i <= 5; i++) begin
      send_clean();
      chk($sformatf("relock_w%0d", i), 64'(locked), 64'(i == 5));
    end
    chk("relock_word_cnt", 64'(word_cnt), 64'd16);

    // Clear together with a 3-bit-error word
    next_word(w);
    w[0] = ~w[0]; w[20] = ~w[20]; w[40] = ~w[40];
    send(w, 1'b1, 1'b1);
    chk("clr_bits", 64'(err_bits), 64'd3);
    chk("clr_word_cnt", 64'(word_cnt), 64'd0);
    chk("clr_err_bit_cnt", 64'(err_bit_cnt), 64'd0);
    chk("clr_lock_loss", 64'(lock_loss_cnt), 64'd0);
    chk("clr_locked", 64'(locked), 64'd1);
    send_clean();
    chk("post_clr_word_cnt", 64'(word_cnt), 64'd1);

    // Saturation: 20 more clean words
    for (int i = 0; i < 20; i++) send_clean();
    chk("sat_word_cnt4", 64'(s_word_cnt), 64'd15);
    chk("sat_word_cnt32", 64'(word_cnt), 64'd21);
    chk("sat_err_bit_cnt4", 64'(s_err_bit_cnt), 64'd0);

    // Asynchronous reset between edges
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_locked", 64'(locked), 64'd0);
    chk("arst_word_cnt", 64'(word_cnt), 64'd0);
    chk("arst_err_bit_cnt", 64'(err_bit_cnt), 64'd0);
    chk("arst_lock_loss", 64'(lock_loss_cnt), 64'd0);
    chk("arst_sat_word_cnt", 64'(s_word_cnt), 64'd0);
    @(negedge clk);
    data_valid = 1'b0;
    rst = 1'b0;

    // Zero words never seed
    for (int i = 0; i < 3; i++) begin
      send('0, 1'b1, 1'b0);
      chk("zero_locked", 64'(locked), 64'd0);
      chk("zero_err_valid", 64'(err_valid), 64'd0);
    end

    // Gapped stream: five valid words needed, idle cycles change nothing
    for (int i = 1; i <= 5; i++) begin
      send_clean();
      chk($sformatf("gap_valid_w%0d", i), 64'(locked), 64'(i == 5));
      send(ones, 1'b0, 1'b0);
      chk($sformatf("gap_idle_w%0d", i), 64'(locked), 64'(i == 5));
    end
    chk("gap_word_cnt", 64'(word_cnt), 64'd0);
    send_clean();
    chk("gap_locked_ev", 64'({err_valid, err_word}), 64'b10);
    send(ones, 1'b0, 1'b0);
    chk("gap_idle_ev", 64'(err_valid), 64'd0);
    chk("gap_idle_word_cnt", 64'(word_cnt), 64'd1);
    send_clean();
    chk("gap_resume", 64'({err_valid, err_word}), 64'b10);
    chk("gap_resume_cnt", 64'(word_cnt), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/example_hmc_prbs_checker.md
Name: example_hmc_prbs_checker

Overview:
- Receive-side PRBS checker for the HMC example traffic path.
- Takes words produced by the PRBS generator (bit 0 is the earliest LFSR output, Fibonacci right-shift, feedback into the MSB).
- Self-synchronises its own LFSR from the incoming data, declares lock, then reports per-word bit errors and accumulates statistics.
- Sits after the HMC read-data return, feeding status registers.

Parameters:
- DATA_WIDTH, 48, word width in bits; must be >= PRBS_SIZE.
- PRBS_SIZE, 15, LFSR length.
- PRBS_POLY, 15'b100000000000011, feedback taps; same encoding as the generator.
- LOCK_COUNT, 4, consecutive matching words required to declare lock (1..255).
- UNLOCK_COUNT, 4, consecutive mismatching words in LOCKED that force relock (1..255).
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- clear_cnt  in  1  synchronous clear of the statistics counters.
- data_valid  in  1  data_in qualifier.
- data_in  in  DATA_WIDTH  received PRBS word.
- locked  out  1  high while the FSM is in LOCKED.
- err_valid  out  1  one-cycle strobe; a LOCKED word has been checked.
- err_word  out  1  checked word had at least one bit error; valid with err_valid.
- err_bits  out  clog2(DATA_WIDTH+1)  popcount of mismatched bits; valid with err_valid.
- word_cnt  out  CNT_WIDTH  words checked while LOCKED; saturating.
- err_bit_cnt  out  CNT_WIDTH  sum of err_bits; saturating.
- lock_loss_cnt  out  16  LOCKED-to-SEEK transitions; saturating.

Behaviour:
Reset:
- rst forces FSM=SEEK and clears exp_state, good_cnt and bad_cnt.
- All outputs reset to 0.

Generator function:
- adv(s) is s advanced DATA_WIDTH steps: for each step, new MSB = ^(PRBS_POLY & {0, s[P-2:0]}), then shift right.
- gen(s) is the DATA_WIDTH output bits, where bit i = s[0] before step i.
- Consequence: gen(s)[P-1:0] == s. The seed for a received word is therefore data_in[P-1:0].

Idle:
- Nothing changes on cycles with data_valid=0.
- Outputs err_valid, err_word and err_bits drop to 0 on those cycles.

FSM (evaluated only when data_valid=1):
- SEEK:
  - seed = data_in[P-1:0].
  - If seed==0, stay in SEEK (the all-zero lockup state is never accepted).
  - Otherwise exp_state <= adv(seed), good_cnt <= 0, go to TRAIN.
- TRAIN:
  - Compare data_in with gen(exp_state).
  - On match: exp_state <= adv(exp_state) and good_cnt+1. When good_cnt+1==LOCK_COUNT, go to LOCKED with bad_cnt <= 0.
  - On mismatch: reseed from data_in exactly as in SEEK, with good_cnt <= 0. A zero seed returns the FSM to SEEK.
- LOCKED:
  - exp_state <= adv(exp_state) on every word; the checker never reseeds from data.
  - diff = data_in ^ gen(exp_state).
  - Mismatch: bad_cnt+1. When bad_cnt+1==UNLOCK_COUNT, go to SEEK and increment lock_loss_cnt.
  - Match: bad_cnt <= 0.
- Minimum lock time: LOCK_COUNT+1 valid words.

Outputs:
- All outputs are registered.
- For a valid word accepted in LOCKED, err_valid, err_word and err_bits assert on the next clock edge (latency 1).
- No err_valid is produced in SEEK or TRAIN.
- The word that causes the transition to LOCKED is not reported.
- The word that causes the transition to SEEK is reported, with err_word=1.
- locked updates on the same edge as the FSM state.

Counters:
- word_cnt += 1 and err_bit_cnt += err_bits for each LOCKED word, updated on the same edge as err_valid.
- All counters saturate at all-ones and never wrap.
- clear_cnt zeroes word_cnt, err_bit_cnt and lock_loss_cnt.
- clear_cnt has priority: any same-cycle increment is dropped.
- clear_cnt does not affect the FSM or locked.

Reset mid-stream:
- The FSM returns to SEEK immediately and asynchronously.
- Relock requires a fresh seed word after rst deasserts.

Test Plan:
- Lock from reset: generator stream, seed 15'h0001, 48-bit, LOCK_COUNT=4, continuous valid.
  - Required: locked rises on the edge after the 5th valid word.
  - Required: 10 further words give word_cnt=10 and err_bit_cnt=0.
- Single bit error: in LOCKED, flip bit 7 of one word.
  - Required: one err_valid with err_word=1 and err_bits=1.
  - Required: locked stays high and err_bit_cnt=1.
  - Required: the next word shows err_word=0, proving no reseed occurred.
- Lock loss: in LOCKED, inject 4 consecutive all-ones words.
  - Required: 4 err_word strobes, locked falls on the 4th, lock_loss_cnt=1.
  - Required: clean data afterwards relocks after 5 words.
- Zero seed and gaps:
  - Feed zero words: the FSM stays in SEEK and locked stays 0.
  - Then feed a clean stream with data_valid toggling 1,0,1,0: lock after 5 valid words, with no state change on idle cycles.
- Clear and saturation:
  - clear_cnt asserted together with a 3-bit-error word: counters read 0 next cycle.
  - With CNT_WIDTH=4, 20 clean LOCKED words give word_cnt=15 (saturated).
- Async reset: assert rst mid-LOCKED between clock edges.
  - Required: locked and all counters read 0 immediately, and the FSM is in SEEK.
